// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_DLY = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_DONE     = 2'd2,
      ST_ERR      = 2'd3
   } rs_state_e;

   localparam int DEF_NO_DOMAINS  = 4;
   localparam int DEF_RELEASE_DLY = 16;
   localparam int DEF_ACK_TIMEOUT = 255;

endpackage

// File: rtl/rs_cycle_cnt.sv
// Shared up-counter with synchronous clear, enable and terminal-count compare.
module rs_cycle_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_tc_val,
   output logic             o_tc
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tc = (cnt_q == i_tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Releases reset domains one at a time in index order, waiting a fixed delay
// and then a per-domain ack before moving to the next domain.
//
// state    | meaning
// WAIT_DLY | counting release delay for domain idx (still in reset)
// WAIT_ACK | domain idx released, waiting for its ack or the timeout
// DONE     | every domain released and acknowledged
// ERR      | ack timeout on domain idx; idx and above held in reset
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NO_DOMAINS  = DEF_NO_DOMAINS,
   parameter int RELEASE_DLY = DEF_RELEASE_DLY,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic                          i_clk,
   input  logic                          i_arst,
   input  logic                          i_sw_rst_req,
   input  logic [NO_DOMAINS-1:0]         i_dom_ack,
   output logic [NO_DOMAINS-1:0]         o_dom_rst,
   output logic [$clog2(NO_DOMAINS)-1:0] o_cur_dom,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_timeout_err
);

   localparam int IDX_W   = $clog2(NO_DOMAINS);
   localparam int CNT_MAX = (RELEASE_DLY > ACK_TIMEOUT) ? RELEASE_DLY : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_DOMAINS - 1);
   localparam logic [CNT_W-1:0] DLY_TC   = CNT_W'(RELEASE_DLY - 1);
   localparam logic [CNT_W-1:0] TO_TC    = CNT_W'(ACK_TIMEOUT - 1);

   rs_state_e             state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NO_DOMAINS-1:0] dom_rst_q, dom_rst_d;
   logic                  cnt_clr, cnt_en, cnt_tc;
   logic [CNT_W-1:0]      tc_val;

   assign tc_val = (state_q == ST_WAIT_ACK) ? TO_TC : DLY_TC;

   rs_cycle_cnt #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .i_clk    (i_clk),
      .i_arst   (i_arst),
      .i_clr    (cnt_clr),
      .i_en     (cnt_en),
      .i_tc_val (tc_val),
      .o_tc     (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      dom_rst_d = dom_rst_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      if (i_sw_rst_req) begin
         state_d   = ST_WAIT_DLY;
         idx_d     = '0;
         dom_rst_d = '1;
         cnt_clr   = 1'b1;
      end else begin
         case (state_q)
            ST_WAIT_DLY: begin
               if (cnt_tc) begin
                  for (int i = 0; i < NO_DOMAINS; i++) begin
                     if (idx_q == IDX_W'(i)) dom_rst_d[i] = 1'b0;
                  end
                  cnt_clr = 1'b1;
                  state_d = ST_WAIT_ACK;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            ST_WAIT_ACK: begin
               if (i_dom_ack[idx_q]) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     cnt_clr = 1'b1;
                     state_d = ST_WAIT_DLY;
                  end
               end else if (cnt_tc) begin
                  // A domain that never acked is put back into reset with the rest.
                  for (int i = 0; i < NO_DOMAINS; i++) begin
                     if (idx_q == IDX_W'(i)) dom_rst_d[i] = 1'b1;
                  end
                  state_d = ST_ERR;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q   <= ST_WAIT_DLY;
         idx_q     <= '0;
         dom_rst_q <= '1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         dom_rst_q <= dom_rst_d;
      end
   end

   assign o_dom_rst     = dom_rst_q;
   assign o_cur_dom     = idx_q;
   assign o_busy        = (state_q == ST_WAIT_DLY) || (state_q == ST_WAIT_ACK);
   assign o_done        = (state_q == ST_DONE);
   assign o_timeout_err = (state_q == ST_ERR);

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NO_DOMAINS, default 4, number of sequenced reset domains (>=2).
REQ-002 SHALL have parameter RELEASE_DLY, default 16, clock cycles each domain waits before its reset is released (>=2).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, maximum WAIT_ACK cycles before error (>=2).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_arst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_sw_rst_req  input  1  single-cycle request to re-sequence all domains.
REQ-007 SHALL have port i_dom_ack  input  NO_DOMAINS  per-domain ready, synchronous to i_clk.
REQ-008 SHALL have port o_dom_rst  output  NO_DOMAINS  per-domain reset, active-high, registered.
REQ-009 SHALL have port o_cur_dom  output  $clog2(NO_DOMAINS)  index of the domain being sequenced.
REQ-010 SHALL have port o_busy  output  1  high in WAIT_DLY and WAIT_ACK.
REQ-011 SHALL have port o_done  output  1  high in DONE.
REQ-012 SHALL have port o_timeout_err  output  1  high in ERR.

Function
REQ-013 SHALL implement FSM states WAIT_DLY, WAIT_ACK, DONE, ERR, with one delay/timeout counter and a domain index.
REQ-014 WAIT_DLY: counter SHALL increment each cycle; at count RELEASE_DLY-1 the next edge SHALL clear o_dom_rst[idx], zero the counter and enter WAIT_ACK.
REQ-015 WAIT_ACK: if i_dom_ack[idx]=1, the next edge SHALL enter DONE when idx=NO_DOMAINS-1, otherwise increment idx, zero the counter and enter WAIT_DLY.
REQ-016 WAIT_ACK: without ack, the counter SHALL increment; at count ACK_TIMEOUT-1 the next edge SHALL enter ERR.
REQ-017 When ack and timeout occur in the same cycle, ack SHALL win.
REQ-018 In WAIT_ACK, only i_dom_ack[idx] SHALL be sampled; other ack bits SHALL be ignored, including a released domain's ack dropping later.
REQ-019 Domains SHALL be released strictly in index order 0..NO_DOMAINS-1; a released domain SHALL stay released until a restart.
REQ-020 In ERR, domains idx..NO_DOMAINS-1 SHALL remain in reset.
REQ-021 i_sw_rst_req=1 in any state SHALL, at the next edge, set o_dom_rst to all ones, set idx=0, zero the counter and enter WAIT_DLY.
REQ-022 i_sw_rst_req SHALL take priority over every other transition.
REQ-023 With ack held high, domain k SHALL release at edge (k+1)*RELEASE_DLY+k after reset deassertion, and DONE SHALL be entered at edge NO_DOMAINS*(RELEASE_DLY+1).
REQ-024 o_busy, o_done, o_timeout_err and o_cur_dom SHALL be decoded from the registered state and idx only.

Reset
REQ-025 While i_arst=1, outputs SHALL be: o_dom_rst all ones, state WAIT_DLY, idx 0, counter 0, o_busy 1, o_done 0, o_timeout_err 0, o_cur_dom 0.
REQ-026 Asserting i_arst mid-sequence SHALL immediately reassert all domain resets without waiting for a clock edge.
REQ-027 Sequencing SHALL restart from domain 0 on the first edge after i_arst deasserts.

Structure
REQ-028 Package reset_seq_pkg SHALL hold the state enum type and the default parameter constants.
REQ-029 One sub-module, rs_cycle_cnt, SHALL hold the shared counter (clear, enable and terminal-count compare).
REQ-030 FSM and o_dom_rst register SHALL reside in reset_sequencer; no combinational path from any input to any output.

Verification
REQ-031 Defaults, i_dom_ack=4'b1111 from reset -> o_dom_rst releases bits 0,1,2,3 at edges 16,33,50,67 and o_done=1 from edge 68.
REQ-032 Ack[1] withheld -> 255 WAIT_ACK cycles then o_timeout_err=1, o_dom_rst=4'b1110, o_cur_dom=1.
REQ-033 From ERR, pulse i_sw_rst_req and then hold all acks -> o_dom_rst=4'b1111 next edge, then the full sequence as in REQ-031 relative to the request edge.
REQ-034 Ack[2] arriving on the same cycle as timeout count 254 -> no error; idx advances to 3.
REQ-035 i_arst asserted asynchronously mid-WAIT_DLY of domain 2 -> o_dom_rst=4'b1111 before the next edge; sequence restarts at domain 0.
REQ-036 i_sw_rst_req while in DONE, with ack[0] high -> all resets reassert; o_busy=1, o_done=0 next edge.
